// File: rtl/data_sync_mc_pkg.sv
// Shared constants and helpers for the multi-channel CDC synchroniser.
// Optional overflow tracking is enabled with DATA_SYNC_MC_OVF_EN.
package data_sync_mc_pkg;

    localparam int MODE_LEVEL  = 0;
    localparam int MODE_TOGGLE = 1;
    localparam int MAX_CH      = 16;

    function automatic int ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/data_sync_mc_chan.sv
// One CDC channel: enable synchroniser, edge detect, holding register.
// DATA_SYNC_MC_OVF_EN adds a sticky overflow bit with clear input.
module data_sync_mc_chan
    import data_sync_mc_pkg::*;
#(
    parameter int NUM_STAGES  = 2,
    parameter int BUS_WIDTH   = 8,
    parameter int TOGGLE_MODE = MODE_LEVEL
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] unsync_bus,
    input  logic                 bus_enable,
    input  logic                 grant,
    output logic [BUS_WIDTH-1:0] hold_data,
    output logic                 hold_valid
`ifdef DATA_SYNC_MC_OVF_EN
    ,
    input  logic                 ovf_clr,
    output logic                 ovf_flag
`endif
);

    generate
        if (NUM_STAGES < 2) begin : g_bad_stages
            $error("NUM_STAGES must be at least 2");
        end
    endgenerate

    logic [NUM_STAGES-1:0] sync_q;
    logic                  s;
    logic                  s_d;
    logic                  evt;

    assign s   = sync_q[NUM_STAGES-1];
    assign evt = (TOGGLE_MODE == MODE_TOGGLE) ? (s ^ s_d) : (s & ~s_d);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[NUM_STAGES-2:0], bus_enable};
            s_d    <= s;
        end
    end

    // A fresh event beats a same-cycle grant so the newest word is kept.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
        end else if (evt) begin
            hold_data  <= unsync_bus;
            hold_valid <= 1'b1;
        end else if (grant) begin
            hold_valid <= 1'b0;
        end
    end

`ifdef DATA_SYNC_MC_OVF_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ovf_flag <= 1'b0;
        end else if (evt && hold_valid && !grant) begin
            ovf_flag <= 1'b1;
        end else if (ovf_clr) begin
            ovf_flag <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/data_sync_mc.sv
// Multi-channel CDC receiver merged round-robin onto one valid/ready stream.
// Define DATA_SYNC_MC_OVF_EN to expose ovf_flag/ovf_clr.
module data_sync_mc
    import data_sync_mc_pkg::*;
#(
    parameter  int NUM_STAGES  = 2,
    parameter  int BUS_WIDTH   = 8,
    parameter  int NUM_CH      = 4,
    parameter  int TOGGLE_MODE = MODE_LEVEL,
    localparam int CH_W        = ch_w(NUM_CH)
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
    input  logic [NUM_CH-1:0]           bus_enable,
    output logic [BUS_WIDTH-1:0]        sync_bus,
    output logic [CH_W-1:0]             sync_ch,
    output logic                        sync_valid,
    input  logic                        sync_ready
`ifdef DATA_SYNC_MC_OVF_EN
    ,
    output logic [NUM_CH-1:0]           ovf_flag,
    input  logic [NUM_CH-1:0]           ovf_clr
`endif
);

    generate
        if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_ch
            $error("NUM_CH out of range");
        end
    endgenerate

    logic [NUM_CH-1:0][BUS_WIDTH-1:0] hold_data;
    logic [NUM_CH-1:0]                hold_valid;
    logic [NUM_CH-1:0]                grant;
    logic [CH_W-1:0]                  rr_ptr;
    logic [CH_W-1:0]                  gnt_idx;
    logic [CH_W-1:0]                  scan_idx;
    logic                             found;
    logic                             load;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        data_sync_mc_chan #(
            .NUM_STAGES (NUM_STAGES),
            .BUS_WIDTH  (BUS_WIDTH),
            .TOGGLE_MODE(TOGGLE_MODE)
        ) u_chan (
            .CLK       (CLK),
            .RST       (RST),
            .unsync_bus(unsync_bus[c*BUS_WIDTH +: BUS_WIDTH]),
            .bus_enable(bus_enable[c]),
            .grant     (grant[c]),
            .hold_data (hold_data[c]),
            .hold_valid(hold_valid[c])
`ifdef DATA_SYNC_MC_OVF_EN
            ,
            .ovf_clr   (ovf_clr[c]),
            .ovf_flag  (ovf_flag[c])
`endif
        );
    end

    // Scan from the pointer so the first hit is the round-robin winner.
    always_comb begin
        gnt_idx  = '0;
        scan_idx = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            scan_idx = CH_W'((int'(rr_ptr) + i) % NUM_CH);
            if (!found && hold_valid[scan_idx]) begin
                found   = 1'b1;
                gnt_idx = scan_idx;
            end
        end
        load  = found && (!sync_valid || sync_ready);
        grant = load ? (NUM_CH'(1) << gnt_idx) : '0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_bus   <= '0;
            sync_ch    <= '0;
            sync_valid <= 1'b0;
            rr_ptr     <= '0;
        end else if (load) begin
            sync_bus   <= hold_data[gnt_idx];
            sync_ch    <= gnt_idx;
            sync_valid <= 1'b1;
            rr_ptr     <= CH_W'((int'(gnt_idx) + 1) % NUM_CH);
        end else if (sync_ready) begin
            sync_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_sync_mc.sv
// Bench for data_sync_mc: level and toggle instances against a cycle model.
// Overflow checks are active when DATA_SYNC_MC_OVF_EN is defined.
module tb_data_sync_mc;

    localparam int NS = 2;
    localparam int BW = 8;
    localparam int NC = 4;
    localparam int CW = 2;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic [NC*BW-1:0] unsync_bus = '0;
    logic [NC-1:0]   bus_enable = '0;
    logic            sync_ready = 1'b0;
    logic [BW-1:0]   bus_o [2];
    logic [CW-1:0]   ch_o [2];
    logic            valid_o [2];
`ifdef DATA_SYNC_MC_OVF_EN
    logic [NC-1:0]   ovf_o [2];
    logic [NC-1:0]   ovf_clr = '0;
`endif

    always #5 CLK = ~CLK;

    data_sync_mc #(
        .NUM_STAGES(NS), .BUS_WIDTH(BW), .NUM_CH(NC), .TOGGLE_MODE(0)
    ) dut_lv (
        .CLK(CLK), .RST(RST), .unsync_bus(unsync_bus),
        .bus_enable(bus_enable), .sync_bus(bus_o[0]), .sync_ch(ch_o[0]),
        .sync_valid(valid_o[0]), .sync_ready(sync_ready)
`ifdef DATA_SYNC_MC_OVF_EN
        , .ovf_flag(ovf_o[0]), .ovf_clr(ovf_clr)
`endif
    );

    data_sync_mc #(
        .NUM_STAGES(NS), .BUS_WIDTH(BW), .NUM_CH(NC), .TOGGLE_MODE(1)
    ) dut_tg (
        .CLK(CLK), .RST(RST), .unsync_bus(unsync_bus),
        .bus_enable(bus_enable), .sync_bus(bus_o[1]), .sync_ch(ch_o[1]),
        .sync_valid(valid_o[1]), .sync_ready(sync_ready)
`ifdef DATA_SYNC_MC_OVF_EN
        , .ovf_flag(ovf_o[1]), .ovf_clr(ovf_clr)
`endif
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Model state: index 0 = level instance, 1 = toggle instance.
    logic       mv [2];
    logic [7:0] mb [2];
    int         mc [2];
    int         mptr [2];
    logic       pv [2][NC];
    logic [7:0] pd [2][NC];
    logic       mo [2][NC];
    int         ev_due [2][NC];
    logic [7:0] ev_data [2][NC];
    int         last_chg [NC];

    logic [15:0] lg0 [$];
    logic [15:0] lg1 [$];

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int m = 0; m < 2; m++) begin
                mv[m] = 1'b0;
                mb[m] = '0;
                mc[m] = 0;
                mptr[m] = 0;
                for (int c = 0; c < NC; c++) begin
                    pv[m][c] = 1'b0;
                    pd[m][c] = '0;
                    mo[m][c] = 1'b0;
                end
            end
        end else begin
            cyc = cyc + 1;
            for (int m = 0; m < 2; m++) begin
                int g;
                logic set;
                g = -1;
                if (!mv[m] || sync_ready) begin
                    for (int i = 0; i < NC; i++) begin
                        int idx;
                        idx = (mptr[m] + i) % NC;
                        if (g < 0 && pv[m][idx]) g = idx;
                    end
                end
                if (g >= 0) begin
                    mb[m] = pd[m][g];
                    mc[m] = g;
                    mv[m] = 1'b1;
                    mptr[m] = (g + 1) % NC;
                    pv[m][g] = 1'b0;
                end else if (sync_ready) begin
                    mv[m] = 1'b0;
                end
                for (int c = 0; c < NC; c++) begin
                    set = 1'b0;
                    if (ev_due[m][c] == cyc) begin
                        set = pv[m][c];
                        pd[m][c] = ev_data[m][c];
                        pv[m][c] = 1'b1;
                    end
`ifdef DATA_SYNC_MC_OVF_EN
                    if (set) mo[m][c] = 1'b1;
                    else if (ovf_clr[c]) mo[m][c] = 1'b0;
`endif
                end
            end
        end
    end

    always @(posedge CLK) begin
        if (RST) begin
            if (valid_o[0] && sync_ready)
                lg0.push_back({6'b0, ch_o[0], bus_o[0]});
            if (valid_o[1] && sync_ready)
                lg1.push_back({6'b0, ch_o[1], bus_o[1]});
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ent(input int c, input logic [7:0] d);
        logic [1:0] cc;
        cc = 2'(c);
        return {6'b0, cc, d};
    endfunction

    task automatic cmp_model();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("valid[%0d]", m), 32'(valid_o[m]), 32'(mv[m]));
            if (mv[m]) begin
                chk($sformatf("bus[%0d]", m), 32'(bus_o[m]), 32'(mb[m]));
                chk($sformatf("ch[%0d]", m), 32'(ch_o[m]), 32'(mc[m]));
            end
`ifdef DATA_SYNC_MC_OVF_EN
            for (int c = 0; c < NC; c++)
                chk($sformatf("ovf[%0d][%0d]", m, c),
                    32'(ovf_o[m][c]), 32'(mo[m][c]));
`endif
        end
    endtask

    task automatic step();
        @(negedge CLK);
        cmp_model();
    endtask

    task automatic drive_chan(input int c, input logic [7:0] d);
        logic old;
        old = bus_enable[c];
        unsync_bus[c*BW +: BW] = d;
        bus_enable[c] = ~old;
        for (int m = 0; m < 2; m++) begin
            if (m == 1 || !old) begin
                ev_due[m][c] = cyc + 1 + NS;
                ev_data[m][c] = d;
            end
        end
        last_chg[c] = cyc;
    endtask

    task automatic release_rst();
        RST = 1'b1;
        for (int c = 0; c < NC; c++) begin
            if (bus_enable[c]) begin
                for (int m = 0; m < 2; m++) begin
                    ev_due[m][c] = cyc + 1 + NS;
                    ev_data[m][c] = unsync_bus[c*BW +: BW];
                end
            end
            last_chg[c] = cyc;
        end
    endtask

    task automatic zero_checks(input string tag);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("%s_valid[%0d]", tag, m), 32'(valid_o[m]), 32'd0);
            chk($sformatf("%s_bus[%0d]", tag, m), 32'(bus_o[m]), 32'd0);
            chk($sformatf("%s_ch[%0d]", tag, m), 32'(ch_o[m]), 32'd0);
        end
    endtask

    task automatic mid_reset();
        sync_ready = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            for (int c = 0; c < NC; c++)
                if (cyc - last_chg[c] >= 5) drive_chan(c, 8'($urandom));
        end
        @(posedge CLK);
        #2;
        RST = 1'b0;
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < NC; c++) ev_due[m][c] = -1;
        #1;
        zero_checks("midrst");
        repeat (3) step();
        release_rst();
    endtask

    int e, s0, s1, rdy_pct;

    initial begin
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < NC; c++) ev_due[m][c] = -1;
        for (int c = 0; c < NC; c++) last_chg[c] = -100;

        repeat (3) step();
        zero_checks("reset");
        release_rst();
        repeat (5) step();

        // Single level event on ch0.
        sync_ready = 1'b1;
        drive_chan(0, 8'hA5);
        e = cyc;
        while (cyc < e + 3) step();
        chk("t1_early_lv", 32'(valid_o[0]), 32'd0);
        chk("t1_early_tg", 32'(valid_o[1]), 32'd0);
        step();
        for (int m = 0; m < 2; m++) begin
            chk("t1_valid", 32'(valid_o[m]), 32'd1);
            chk("t1_bus", 32'(bus_o[m]), 32'hA5);
            chk("t1_ch", 32'(ch_o[m]), 32'd0);
        end
        step();
        chk("t1_once_lv", 32'(valid_o[0]), 32'd0);
        chk("t1_once_tg", 32'(valid_o[1]), 32'd0);

        // Three toggles on ch1.
        s0 = lg0.size();
        s1 = lg1.size();
        drive_chan(1, 8'h11);
        repeat (10) step();
        drive_chan(1, 8'h22);
        repeat (10) step();
        drive_chan(1, 8'h33);
        repeat (10) step();
        chk("t2_tg_n", 32'(lg1.size() - s1), 32'd3);
        chk("t2_tg0", 32'(lg1[s1]), 32'(ent(1, 8'h11)));
        chk("t2_tg1", 32'(lg1[s1+1]), 32'(ent(1, 8'h22)));
        chk("t2_tg2", 32'(lg1[s1+2]), 32'(ent(1, 8'h33)));
        chk("t2_lv_n", 32'(lg0.size() - s0), 32'd2);
        chk("t2_lv0", 32'(lg0[s0]), 32'(ent(1, 8'h11)));
        chk("t2_lv1", 32'(lg0[s0+1]), 32'(ent(1, 8'h33)));

        // Two all-channel bursts; order follows the pointer.
        s0 = lg0.size();
        s1 = lg1.size();
        for (int c = 0; c < NC; c++) drive_chan(c, 8'(8'hC0 + c));
        repeat (10) step();
        for (int k = 0; k < 4; k++)
            chk("t3_tg", 32'(lg1[s1+k]),
                32'(ent((k + 2) % 4, 8'(8'hC0 + (k + 2) % 4))));
        chk("t3_lv0", 32'(lg0[s0]), 32'(ent(2, 8'hC2)));
        chk("t3_lv1", 32'(lg0[s0+1]), 32'(ent(3, 8'hC3)));
        s0 = lg0.size();
        s1 = lg1.size();
        for (int c = 0; c < NC; c++) drive_chan(c, 8'(8'hD0 + c));
        repeat (10) step();
        for (int k = 0; k < 4; k++)
            chk("t3b_tg", 32'(lg1[s1+k]),
                32'(ent((k + 2) % 4, 8'(8'hD0 + (k + 2) % 4))));
        chk("t3b_lv0", 32'(lg0[s0]), 32'(ent(0, 8'hD0)));
        chk("t3b_lv1", 32'(lg0[s0+1]), 32'(ent(1, 8'hD1)));

        // Stalled consumer, ch2 overwritten while waiting.
        sync_ready = 1'b0;
        s0 = lg0.size();
        s1 = lg1.size();
        drive_chan(0, 8'h44);
        repeat (6) step();
        drive_chan(2, 8'h5A);
        repeat (6) step();
        drive_chan(2, 8'h6B);
        repeat (8) step();
        chk("t4_hold_v", 32'(valid_o[1]), 32'd1);
        chk("t4_hold_b", 32'(bus_o[1]), 32'h44);
        chk("t4_hold_lv", 32'(bus_o[0]), 32'h5A);
`ifdef DATA_SYNC_MC_OVF_EN
        chk("t4_ovf_tg", 32'(ovf_o[1][2]), 32'd1);
        chk("t4_ovf_lv", 32'(ovf_o[0][2]), 32'd0);
        ovf_clr[2] = 1'b1;
        step();
        ovf_clr = '0;
        chk("t4_clr_tg", 32'(ovf_o[1][2]), 32'd0);
`endif
        sync_ready = 1'b1;
        repeat (6) step();
        chk("t4_tg_n", 32'(lg1.size() - s1), 32'd2);
        chk("t4_tg0", 32'(lg1[s1]), 32'(ent(0, 8'h44)));
        chk("t4_tg1", 32'(lg1[s1+1]), 32'(ent(2, 8'h6B)));
        chk("t4_lv0", 32'(lg0[s0]), 32'(ent(2, 8'h5A)));

        // Random traffic with periodic mid-operation resets.
        for (int r = 0; r < 3; r++) begin
            for (int n = 0; n < 1000; n++) begin
                step();
                if (n % 100 == 0) begin
                    case ($urandom_range(0, 3))
                        0: rdy_pct = 0;
                        1: rdy_pct = 30;
                        2: rdy_pct = 70;
                        default: rdy_pct = 100;
                    endcase
                end
                sync_ready = ($urandom_range(0, 99) < rdy_pct);
`ifdef DATA_SYNC_MC_OVF_EN
                for (int c = 0; c < NC; c++)
                    ovf_clr[c] = ($urandom_range(0, 19) == 0);
`endif
                if ($urandom_range(0, 49) == 0) begin
                    for (int c = 0; c < NC; c++)
                        if (cyc - last_chg[c] >= 5)
                            drive_chan(c, 8'($urandom));
                end else begin
                    for (int c = 0; c < NC; c++)
                        if (cyc - last_chg[c] >= 5 &&
                            $urandom_range(0, 5) == 0)
                            drive_chan(c, 8'($urandom));
                end
            end
`ifdef DATA_SYNC_MC_OVF_EN
            ovf_clr = '0;
`endif
            mid_reset();
        end

        sync_ready = 1'b1;
        repeat (20) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
